enable_tap_shift_register: RTL and testbench
============================================

# enable_tap_shift_register

Parametrised successor to the fixed 4x4 enable shift register: a WIDTH-bit, DEPTH-stage shift chain that advances only when `shift` is high, with a synchronous flush and an occupancy counter. It also has an optional run-time tap selector. It sits in datapath delay-line and sample-window positions, where the fixed-depth register cannot be resized and cannot report how many valid samples it holds.

## Interface
- WIDTH, 4, data width in bits (>=1)
- DEPTH, 4, number of stages (>=2)
- INIT, 0, WIDTH-bit value loaded into every stage on reset and clear
- CLK  input  1  clock; all state updates on rising edge
- RESETN  input  1  reset, synchronous, active-low; sampled only on rising CLK
- I  input  WIDTH  data into stage 0
- shift  input  1  advance enable
- clear  input  1  synchronous flush, active-high
- tap_sel  input  clog2(DEPTH)  stage index for tap_O (only with ESR_TAP_EN)
- O  output  WIDTH  stage DEPTH-1 (oldest)
- tap_O  output  WIDTH  stage tap_sel (only with ESR_TAP_EN)
- count  output  clog2(DEPTH+1)  valid entries held, 0..DEPTH
- full  output  1  count == DEPTH

## Operation
- Stages are stage[0..DEPTH-1]. O = stage[DEPTH-1].
- Priority on each rising CLK: RESETN low, then clear, then shift, then hold.
- RESETN low: every stage <= INIT; count <= 0.
- clear high: every stage <= INIT; count <= 0. shift is ignored that cycle.
- shift high, no reset or clear:
  - stage[0] <= I
  - stage[k] <= stage[k-1] for k = 1..DEPTH-1
  - count <= min(count+1, DEPTH); saturates, never wraps.
- shift low: all stages and count hold.
- full is combinational from count.
- tap_O is combinational: stage[tap_sel] when tap_sel < DEPTH, else all-zero (covers non-power-of-2 DEPTH).
- count tracks shifts since the last reset/clear only. Stage contents are not inspected, so an I value equal to INIT still counts as valid.

## Timing
- Reset values: O = INIT, tap_O = INIT for in-range tap_sel, count = 0, full = 0.
- Latency I -> O: exactly DEPTH shift-enabled edges. Cycles with shift low do not count toward it.
- Latency I -> tap_O at tap_sel = k: k+1 shift-enabled edges.
- No combinational path from I, shift, or clear to O, count, or full. The only combinational path is tap_sel -> tap_O.
- Reset released mid-stream: the first edge with RESETN high and shift high loads I into stage[0] and sets count = 1.
- Simultaneous clear and shift: clear wins; count = 0 next cycle.
- shift high while full: data still advances (the oldest entry is dropped); count stays DEPTH.

## Configuration
- ESR_TAP_EN defined: the tap_sel input and tap_O output exist, with the mux behaving as described above.
- ESR_TAP_EN undefined: tap_sel and tap_O are absent from the port list and no mux logic is generated. All other behaviour is identical.

## Test plan
- Reset: WIDTH=4, DEPTH=4, INIT=0; hold RESETN=0 for 2 edges with shift=1, I=0xF -> O=0x0, count=0, full=0.
- Fill: shift=1 for 4 edges with I=1,2,3,4 -> after edge 4: O=0x1, count=4, full=1; edge 5 with I=5 -> O=0x2, count stays 4.
- Gaps: alternate shift=1/0 with I=0xA,0xB,0xC,0xD on shift cycles -> O=0xA only after the 4th enabled edge (7 edges total); outputs hold on shift=0 edges.
- Clear priority: with the register full, assert clear=1 and shift=1 with I=0x9 -> next cycle every stage = INIT, count=0, full=0; 0x9 not captured.
- Tap (ESR_TAP_EN, DEPTH=5, WIDTH=8): shift in 0x11,0x22,0x33,0x44,0x55 -> tap_sel=0 gives 0x55, tap_sel=4 gives 0x11, tap_sel=7 gives 0x00, each in the same cycle as the tap_sel change.
- Reset mid-operation: RESETN=0 for one edge while count=3, then RESETN=1, shift=1, I=0x7 for one edge -> count=1, stage[0]=0x7, O=INIT.

Source files
------------

// File: rtl/enable_tap_shift_register.sv
// enable_tap_shift_register: WIDTH-bit, DEPTH-stage enabled shift chain with flush and occupancy count
//
// Ports:
//   CLK      in   1              clock, all state updates on rising edge
//   RESETN   in   1              synchronous active-low reset
//   I        in   WIDTH          data into stage 0
//   shift    in   1              advance enable
//   clear    in   1              synchronous flush, active-high (wins over shift)
//   tap_sel  in   clog2(DEPTH)   stage index for tap_O (ESR_TAP_EN only)
//   O        out  WIDTH          oldest stage, stage[DEPTH-1]
//   tap_O    out  WIDTH          stage[tap_sel], zero when tap_sel >= DEPTH (ESR_TAP_EN only)
//   count    out  clog2(DEPTH+1) valid entries since last reset/clear, saturates at DEPTH
//   full     out  1              count == DEPTH
//
// Define ESR_TAP_EN to add the run-time tap selector (tap_sel/tap_O).
module enable_tap_shift_register #(
    parameter int               WIDTH = 4,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic [WIDTH-1:0]           I,
    input  logic                       shift,
    input  logic                       clear,
`ifdef ESR_TAP_EN
    input  logic [$clog2(DEPTH)-1:0]   tap_sel,
    output logic [WIDTH-1:0]           tap_O,
`endif
    output logic [WIDTH-1:0]           O,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);
    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [CW-1:0]    r_count;
    logic             w_full;

    always_ff @(posedge CLK) begin
        if (!RESETN || clear) begin
            for (int k = 0; k < DEPTH; k++) r_stage[k] <= INIT;
            r_count <= '0;
        end else if (shift) begin
            r_stage[0] <= I;
            for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
            // occupancy saturates; a full chain keeps shifting and drops its oldest entry
            r_count <= w_full ? r_count : r_count + CW'(1);
        end
    end

    assign w_full = (r_count == C_DEPTH);
    assign full   = w_full;
    assign count  = r_count;
    assign O      = r_stage[DEPTH-1];

`ifdef ESR_TAP_EN
    // out-of-range selects (non-power-of-2 DEPTH) read as zero
    assign tap_O = (int'(tap_sel) < DEPTH) ? r_stage[tap_sel] : '0;
`endif
endmodule

// File: tb/tb_enable_tap_shift_register.sv
// tb_enable_tap_shift_register: directed and random checks of two shift register configurations against a queue model
module tb_enable_tap_shift_register;
    localparam int          DA     = 4;
    localparam logic [3:0]  INIT_A = 4'h0;
    localparam int          DB     = 5;
    localparam logic [7:0]  INIT_B = 8'hA5;

    logic       clk = 1'b0;
    logic       resetn, shift, clear;
    logic [3:0] i_a, o_a, tap_a;
    logic [7:0] i_b, o_b, tap_b;
    logic [1:0] tap_sel_a;
    logic [2:0] tap_sel_b;
    logic [2:0] cnt_a, cnt_b;
    logic       full_a, full_b;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] ha [$];
    logic [7:0] hb [$];

    always #5 clk = ~clk;

    enable_tap_shift_register #(.WIDTH(4), .DEPTH(DA), .INIT(INIT_A)) dut_a (
        .CLK(clk), .RESETN(resetn), .I(i_a), .shift(shift), .clear(clear),
`ifdef ESR_TAP_EN
        .tap_sel(tap_sel_a), .tap_O(tap_a),
`endif
        .O(o_a), .count(cnt_a), .full(full_a)
    );

    enable_tap_shift_register #(.WIDTH(8), .DEPTH(DB), .INIT(INIT_B)) dut_b (
        .CLK(clk), .RESETN(resetn), .I(i_b), .shift(shift), .clear(clear),
`ifdef ESR_TAP_EN
        .tap_sel(tap_sel_b), .tap_O(tap_b),
`endif
        .O(o_b), .count(cnt_b), .full(full_b)
    );

`ifndef ESR_TAP_EN
    assign tap_a = '0;
    assign tap_b = '0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // newest entry sits at index 0; unfilled stages read INIT, unselectable stages read zero
    function automatic logic [3:0] ea(int k);
        return k >= DA ? 4'h0 : (k < ha.size() ? ha[k] : INIT_A);
    endfunction

    function automatic logic [7:0] eb(int k);
        return k >= DB ? 8'h0 : (k < hb.size() ? hb[k] : INIT_B);
    endfunction

    task automatic compare_all();
        check("A_O", 32'(o_a), 32'(ea(DA-1)));
        check("A_count", 32'(cnt_a), ha.size());
        check("A_full", 32'(full_a), 32'(ha.size() == DA));
        check("B_O", 32'(o_b), 32'(eb(DB-1)));
        check("B_count", 32'(cnt_b), hb.size());
        check("B_full", 32'(full_b), 32'(hb.size() == DB));
`ifdef ESR_TAP_EN
        check("A_tap", 32'(tap_a), 32'(ea(int'(tap_sel_a))));
        check("B_tap", 32'(tap_b), 32'(eb(int'(tap_sel_b))));
`endif
    endtask

    task automatic step(input logic rn, input logic sh, input logic cl, input logic [3:0] a, input logic [7:0] b);
        resetn = rn;
        shift  = sh;
        clear  = cl;
        i_a    = a;
        i_b    = b;
        @(posedge clk);
        if (!rn || cl) begin
            ha.delete();
            hb.delete();
        end else if (sh) begin
            ha.push_front(a);
            hb.push_front(b);
            if (ha.size() > DA) void'(ha.pop_back());
            if (hb.size() > DB) void'(hb.pop_back());
        end
        #1;
        compare_all();
    endtask

    initial begin
        tap_sel_a = '0;
        tap_sel_b = '0;
        step(1'b0, 1'b1, 1'b0, 4'hF, 8'hFF);
        step(1'b0, 1'b1, 1'b0, 4'hF, 8'hFF);
        check("reset_O", 32'(o_a), 32'h0);
        check("reset_count", 32'(cnt_a), 32'h0);
        check("reset_full", 32'(full_a), 32'h0);
        check("reset_B_O", 32'(o_b), 32'hA5);

        for (int k = 1; k <= 4; k++) step(1'b1, 1'b1, 1'b0, 4'(k), 8'(k));
        check("fill_O", 32'(o_a), 32'h1);
        check("fill_count", 32'(cnt_a), 32'h4);
        check("fill_full", 32'(full_a), 32'h1);
        step(1'b1, 1'b1, 1'b0, 4'h5, 8'h5);
        check("fill5_O", 32'(o_a), 32'h2);
        check("fill5_count", 32'(cnt_a), 32'h4);

        step(1'b1, 1'b1, 1'b1, 4'h9, 8'h99);
        check("clear_O", 32'(o_a), 32'h0);
        check("clear_count", 32'(cnt_a), 32'h0);
        check("clear_full", 32'(full_a), 32'h0);
        check("clear_B_O", 32'(o_b), 32'hA5);

        step(1'b1, 1'b1, 1'b0, 4'hA, 8'hA);
        step(1'b1, 1'b0, 1'b0, 4'h1, 8'h1);
        step(1'b1, 1'b1, 1'b0, 4'hB, 8'hB);
        step(1'b1, 1'b0, 1'b0, 4'h2, 8'h2);
        step(1'b1, 1'b1, 1'b0, 4'hC, 8'hC);
        step(1'b1, 1'b0, 1'b0, 4'h3, 8'h3);
        check("gap_early_O", 32'(o_a), 32'h0);
        check("gap_early_count", 32'(cnt_a), 32'h3);
        step(1'b1, 1'b1, 1'b0, 4'hD, 8'hD);
        check("gap_O", 32'(o_a), 32'hA);

        step(1'b1, 1'b0, 1'b1, 4'h0, 8'h0);
        for (int k = 1; k <= 5; k++) step(1'b1, 1'b1, 1'b0, 4'(k), 8'(k * 17));
        check("tapfill_B_O", 32'(o_b), 32'h11);
`ifdef ESR_TAP_EN
        tap_sel_b = 3'd0;
        #1 check("tap0", 32'(tap_b), 32'h55);
        tap_sel_b = 3'd4;
        #1 check("tap4", 32'(tap_b), 32'h11);
        tap_sel_b = 3'd7;
        #1 check("tap7", 32'(tap_b), 32'h00);
        tap_sel_b = 3'd5;
        #1 check("tap5", 32'(tap_b), 32'h00);
`endif

        step(1'b1, 1'b0, 1'b1, 4'h0, 8'h0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 4'h3, 8'h3);
        check("mid_count3", 32'(cnt_a), 32'h3);
        step(1'b0, 1'b0, 1'b0, 4'h0, 8'h0);
        tap_sel_a = 2'd0;
        step(1'b1, 1'b1, 1'b0, 4'h7, 8'h77);
        check("mid_count", 32'(cnt_a), 32'h1);
        check("mid_O", 32'(o_a), 32'h0);
`ifdef ESR_TAP_EN
        check("mid_stage0", 32'(tap_a), 32'h7);
`endif

        for (int n = 0; n < 400; n++) begin
            tap_sel_a = 2'($urandom);
            tap_sel_b = 3'($urandom);
            step($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 14) == 0,
                 4'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
